// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART receive path
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

    localparam int OVERSAMPLE = 16;
    localparam logic [3:0] MID_START = 4'd7;
    localparam logic [3:0] MID_BIT   = 4'd15;

    function automatic int calc_div(input int clk_freq, input int baud_rate);
        return clk_freq / (baud_rate * OVERSAMPLE);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - oversampling tick divider, held at zero while clr is high
module uart_baud_tick #(
    parameter int DIV = 10
) (
    input  logic sysclk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] div_cnt;

    always_ff @(posedge sysclk) begin
        if (reset || clr) begin
            div_cnt <= '0;
        end else if (div_cnt == LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + W'(1);
        end
    end

    assign tick = (div_cnt == LAST);

endmodule

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 16x oversampled 8N1 UART receiver with frame error and break handling
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 100000000,
    parameter int BAUD_RATE = 9600
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       uart_rx,
    output logic [7:0] rx_data,
    output logic       rx_status,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int DIV = calc_div(CLK_FREQ, BAUD_RATE);

    rx_state_t  state, next_state;
    logic [1:0] sync;
    logic       rx_s;
    logic       tick;
    logic       clr;
    logic       mid_start;
    logic       bit_done;
    logic [3:0] tick_cnt;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;

    assign rx_s = sync[1];

    // Divider is held in IDLE so bit timing starts at the detected falling edge
    uart_baud_tick #(.DIV(DIV)) u_tick (
        .sysclk (sysclk),
        .reset  (reset),
        .clr    (clr),
        .tick   (tick)
    );

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (!rx_s) next_state = START;
            START:   if (mid_start) next_state = rx_s ? IDLE : DATA;
            DATA:    if (bit_done && bit_cnt == 3'd7) next_state = STOP;
            STOP:    if (bit_done) next_state = rx_s ? IDLE : BREAK;
            BREAK:   if (rx_s) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        clr       = (state == IDLE);
        rx_busy   = (state != IDLE);
        mid_start = tick && (tick_cnt == MID_START);
        bit_done  = tick && (tick_cnt == MID_BIT);
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            sync      <= 2'b11;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            rx_data   <= '0;
            rx_status <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            sync      <= {sync[0], uart_rx};
            rx_status <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                START: begin
                    bit_cnt <= '0;
                    if (tick) tick_cnt <= mid_start ? 4'd0 : tick_cnt + 4'd1;
                end
                DATA: begin
                    // tick_cnt wraps 15->0 on its own, which also zeroes it for STOP
                    if (tick) tick_cnt <= tick_cnt + 4'd1;
                    if (bit_done) begin
                        shreg[bit_cnt] <= rx_s;
                        bit_cnt        <= bit_cnt + 3'd1;
                    end
                end
                STOP: begin
                    if (tick) tick_cnt <= tick_cnt + 4'd1;
                    if (bit_done) begin
                        if (rx_s) begin
                            rx_data   <= shreg;
                            rx_status <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                end
                default: begin
                    tick_cnt <= '0;
                    bit_cnt  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - directed self-checking bench for uart_receiver
module tb_uart_receiver;

    localparam int BIT_CYC = 160;

    logic       sysclk = 1'b0;
    logic       reset = 1'b1;
    logic       uart_rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_status;
    logic       frame_err;
    logic       rx_busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int status_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    int bad_change = 0;
    int last_cyc = 0;
    int start_cyc = 0;
    logic [7:0] prev_data = 8'h00;
    logic [7:0] got_q[$];

    uart_receiver #(.CLK_FREQ(1600000), .BAUD_RATE(10000)) dut (
        .sysclk    (sysclk),
        .reset     (reset),
        .uart_rx   (uart_rx),
        .rx_data   (rx_data),
        .rx_status (rx_status),
        .frame_err (frame_err),
        .rx_busy   (rx_busy)
    );

    always #5 sysclk = ~sysclk;

    always @(posedge sysclk) cyc <= cyc + 1;

    always @(negedge sysclk) begin
        if (!reset) begin
            if (rx_status) begin
                status_cnt = status_cnt + 1;
                last_cyc = cyc;
                got_q.push_back(rx_data);
            end
            if (frame_err) err_cnt = err_cnt + 1;
            if (rx_status && frame_err) both_cnt = both_cnt + 1;
            if (rx_data !== prev_data && !rx_status) bad_change = bad_change + 1;
        end
        prev_data = rx_data;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    task automatic clear_counts();
        status_cnt = 0;
        err_cnt = 0;
        got_q.delete();
    endtask

    task automatic send_bit(input logic b, input int n);
        uart_rx = b;
        wait_cyc(n);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop_val);
        send_bit(1'b0, BIT_CYC);
        for (int i = 0; i < 8; i++) send_bit(d[i], BIT_CYC);
        send_bit(stop_val, BIT_CYC);
    endtask

    initial begin
        // 1: reset
        reset = 1'b1;
        uart_rx = 1'b1;
        wait_cyc(3);
        reset = 1'b0;
        check("reset_rx_data", {24'd0, rx_data}, 32'h00);
        check("reset_rx_status", {31'd0, rx_status}, 32'd0);
        check("reset_frame_err", {31'd0, frame_err}, 32'd0);
        check("reset_rx_busy", {31'd0, rx_busy}, 32'd0);
        wait_cyc(20);

        // 2: single byte and start-edge-to-strobe latency
        clear_counts();
        start_cyc = cyc;
        send_byte(8'hA5, 1'b1);
        wait_cyc(200);
        check("a5_count", status_cnt, 1);
        check("a5_data", {24'd0, rx_data}, 32'hA5);
        check("a5_no_ferr", err_cnt, 0);
        check("a5_latency_ok", ((last_cyc - start_cyc) >= 1521 && (last_cyc - start_cyc) <= 1525) ? 1 : 0, 1);

        // 3: back-to-back frames
        clear_counts();
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        wait_cyc(200);
        check("b2b_count", status_cnt, 2);
        check("b2b_first", (got_q.size() > 0) ? {24'd0, got_q[0]} : 32'hDEAD, 32'h00);
        check("b2b_second", (got_q.size() > 1) ? {24'd0, got_q[1]} : 32'hDEAD, 32'hFF);

        // 4: short low glitch is rejected at mid start bit
        clear_counts();
        uart_rx = 1'b0;
        wait_cyc(20);
        check("glitch_busy", {31'd0, rx_busy}, 32'd1);
        wait_cyc(30);
        uart_rx = 1'b1;
        wait_cyc(60);
        check("glitch_idle", {31'd0, rx_busy}, 32'd0);
        check("glitch_no_status", status_cnt, 0);
        check("glitch_no_ferr", err_cnt, 0);

        // 5: framing error with line held low, then recovery
        clear_counts();
        send_byte(8'h3C, 1'b0);
        send_bit(1'b0, 2 * BIT_CYC);
        check("break_busy", {31'd0, rx_busy}, 32'd1);
        check("ferr_data_held", {24'd0, rx_data}, 32'hFF);
        send_bit(1'b1, BIT_CYC);
        check("ferr_single", err_cnt, 1);
        check("ferr_no_status", status_cnt, 0);
        send_byte(8'h55, 1'b1);
        wait_cyc(200);
        check("after_ferr_count", status_cnt, 1);
        check("after_ferr_data", {24'd0, rx_data}, 32'h55);
        check("ferr_total", err_cnt, 1);

        // 6: reset in the middle of data bit 4
        clear_counts();
        send_bit(1'b0, BIT_CYC);
        for (int i = 0; i < 4; i++) send_bit(((8'hC3 >> i) & 8'h01) != 0, BIT_CYC);
        send_bit(1'b0, BIT_CYC / 2);
        reset = 1'b1;
        uart_rx = 1'b1;
        wait_cyc(3);
        check("midreset_busy", {31'd0, rx_busy}, 32'd0);
        check("midreset_data", {24'd0, rx_data}, 32'h00);
        reset = 1'b0;
        wait_cyc(BIT_CYC);
        check("midreset_no_status", status_cnt, 0);
        send_byte(8'h81, 1'b1);
        wait_cyc(200);
        check("post_reset_count", status_cnt, 1);
        check("post_reset_data", {24'd0, rx_data}, 32'h81);

        check("never_both", both_cnt, 0);
        check("data_only_on_status", bad_change, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
